// File: rtl/param_dynamic_shift_reg.sv
// rtl/param_dynamic_shift_reg.sv - parametrised multi-bit shift register with dynamic tap and fill tracking
// Programmable delay line: a word shifted in appears at tap A after A further enabled shifts.
module param_dynamic_shift_reg #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int CW      = 5,
  parameter int OUT_REG = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    A,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  output logic             FULL,
  output logic [CW-1:0]    COUNT,
  output logic             ADDR_ERR
);

  if (DEPTH < 2 || DEPTH > (1 << AW) || (1 << CW) <= DEPTH) begin : g_param_check
    $fatal(1, "param_dynamic_shift_reg: illegal DEPTH/AW/CW combination");
  end

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] s_q [DEPTH];
  logic [WIDTH-1:0] s_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             addr_ok;
  logic [WIDTH-1:0] tap_q;
  logic             tap_v;

  always_comb begin
    s_d     = s_q;
    count_d = count_q;
    if (CLR) begin
      for (int i = 0; i < DEPTH; i++) s_d[i] = '0;
      count_d = '0;
    end else if (CE) begin
      s_d[0] = D;
      for (int i = 1; i < DEPTH; i++) s_d[i] = s_q[i-1];
      if (count_q != DEPTH_C) count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) s_q[i] <= '0;
      count_q <= '0;
    end else begin
      s_q     <= s_d;
      count_q <= count_d;
    end
  end

  // Out-of-range taps fall through the select loop and read as zero.
  always_comb begin
    addr_ok = 32'(A) < DEPTH;
    tap_q   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (32'(A) == i) tap_q = s_q[i];
    end
    tap_v = addr_ok && (32'(count_q) > 32'(A));
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             q_valid_q;
    logic             q_valid_d;

    always_comb begin
      q_d       = tap_q;
      q_valid_d = tap_v;
    end

    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        q_q       <= '0;
        q_valid_q <= 1'b0;
      end else begin
        q_q       <= q_d;
        q_valid_q <= q_valid_d;
      end
    end

    assign Q       = q_q;
    assign Q_VALID = q_valid_q;
  end else begin : g_comb
    assign Q       = tap_q;
    assign Q_VALID = tap_v;
  end

  assign FULL     = (count_q == DEPTH_C);
  assign COUNT    = count_q;
  assign ADDR_ERR = !addr_ok;

endmodule

// File: tb/tb_param_dynamic_shift_reg.sv
// tb/tb_param_dynamic_shift_reg.sv - self-checking bench for param_dynamic_shift_reg
// Three instances share stimulus: default, DEPTH=12, and registered output.
module tb_param_dynamic_shift_reg;

  logic       CLK = 1'b0;
  logic       RST_N, CE, CLR;
  logic [7:0] D;
  logic [3:0] A;

  logic [7:0] q0, q1, q2;
  logic       v0, v1, v2, f0, f1, f2, e0, e1, e2;
  logic [4:0] c0, c2;
  logic [3:0] c1;

  always #5 CLK = ~CLK;

  param_dynamic_shift_reg #(.WIDTH(8), .DEPTH(16), .AW(4), .CW(5), .OUT_REG(0)) u0 (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .CLR(CLR), .D(D), .A(A),
    .Q(q0), .Q_VALID(v0), .FULL(f0), .COUNT(c0), .ADDR_ERR(e0));

  param_dynamic_shift_reg #(.WIDTH(8), .DEPTH(12), .AW(4), .CW(4), .OUT_REG(0)) u1 (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .CLR(CLR), .D(D), .A(A),
    .Q(q1), .Q_VALID(v1), .FULL(f1), .COUNT(c1), .ADDR_ERR(e1));

  param_dynamic_shift_reg #(.WIDTH(8), .DEPTH(16), .AW(4), .CW(5), .OUT_REG(1)) u2 (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .CLR(CLR), .D(D), .A(A),
    .Q(q2), .Q_VALID(v2), .FULL(f2), .COUNT(c2), .ADDR_ERR(e2));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference storage, newest word at index 0.
  logic [7:0] m16 [16];
  logic [7:0] m12 [12];
  int         n16, n12;
  logic [8:0] sbq [$];
  logic [8:0] last_exp;

  function automatic logic [8:0] tap16(input int a);
    return {n16 > a, m16[a]};
  endfunction

  function automatic logic [8:0] tap12(input int a);
    if (a >= 12) return 9'h000;
    return {n12 > a, m12[a]};
  endfunction

  task automatic model_update(input logic rst_n, input logic ce, input logic clr, input logic [7:0] d);
    if (!rst_n || clr) begin
      foreach (m16[i]) m16[i] = 8'h00;
      foreach (m12[i]) m12[i] = 8'h00;
      n16 = 0;
      n12 = 0;
    end else if (ce) begin
      for (int i = 15; i > 0; i--) m16[i] = m16[i-1];
      for (int i = 11; i > 0; i--) m12[i] = m12[i-1];
      m16[0] = d;
      m12[0] = d;
      if (n16 < 16) n16++;
      if (n12 < 12) n12++;
    end
  endtask

  task automatic step(input logic rst_n, input logic ce, input logic clr, input logic [7:0] d, input logic [3:0] a);
    logic [8:0] exp12;
    RST_N = rst_n; CE = ce; CLR = clr; D = d; A = a;
    sbq.push_back(rst_n ? tap16(int'(a)) : 9'h000);
    @(posedge CLK);
    model_update(rst_n, ce, clr, d);
    #1;
    last_exp = sbq.pop_front();
    chk("oreg_q", q2, last_exp[7:0]);
    chk("oreg_valid", v2, last_exp[8]);
    chk("oreg_count", c2, n16);
    exp12 = tap12(int'(a));
    chk("d12_q", q1, exp12[7:0]);
    chk("d12_valid", v1, exp12[8]);
    chk("d12_count", c1, n12);
    chk("d12_full", f1, n12 == 12);
    chk("d12_addr_err", e1, a >= 4'd12);
  endtask

  typedef struct {
    logic       rst_n;
    logic       ce;
    logic       clr;
    logic [7:0] d;
    logic [3:0] a;
    logic [7:0] eq;
    logic       ev;
    int         ec;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(input logic rst_n, input logic ce, input logic clr, input logic [7:0] d,
                              input logic [3:0] a, input logic [7:0] eq, input logic ev, input int ec);
    vec_t v;
    v.rst_n = rst_n; v.ce = ce; v.clr = clr; v.d = d; v.a = a;
    v.eq = eq; v.ev = ev; v.ec = ec;
    tbl.push_back(v);
  endfunction

  initial begin
    RST_N = 1'b0; CE = 1'b0; CLR = 1'b0; D = 8'h00; A = 4'h0;

    add(0, 1, 0, 8'hFF, 0, 8'h00, 0, 0);
    add(0, 1, 0, 8'hFF, 0, 8'h00, 0, 0);
    for (int k = 1; k <= 20; k++)
      add(1, 1, 0, 8'(k), 3, (k >= 4) ? 8'(k - 3) : 8'h00, k >= 4, (k < 16) ? k : 16);
    add(1, 0, 0, 8'h77, 15, 8'h05, 1, 16);
    add(1, 1, 0, 8'h21, 0, 8'h21, 1, 16);
    add(1, 0, 0, 8'h99, 0, 8'h21, 1, 16);
    add(1, 0, 0, 8'h98, 1, 8'h14, 1, 16);
    add(1, 1, 0, 8'h22, 0, 8'h22, 1, 16);
    add(1, 1, 1, 8'hAA, 0, 8'h00, 0, 0);
    add(1, 0, 0, 8'hAA, 5, 8'h00, 0, 0);
    add(1, 1, 0, 8'h07, 0, 8'h07, 1, 1);
    add(0, 1, 1, 8'h55, 0, 8'h00, 0, 0);
    for (int k = 1; k <= 5; k++)
      add(1, 1, 0, 8'(k), 0, 8'(k), 1, k);
    add(0, 1, 0, 8'hFF, 4, 8'h00, 0, 0);
    add(1, 0, 0, 8'h00, 4, 8'h00, 0, 0);
    add(1, 0, 0, 8'h00, 0, 8'h00, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].ce, tbl[i].clr, tbl[i].d, tbl[i].a);
      chk($sformatf("v%0d_q", i), q0, tbl[i].eq);
      chk($sformatf("v%0d_valid", i), v0, tbl[i].ev);
      chk($sformatf("v%0d_count", i), c0, tbl[i].ec);
      chk($sformatf("v%0d_full", i), f0, tbl[i].ec == 16);
      chk($sformatf("v%0d_addr_err", i), e0, 0);
    end

    // DEPTH=12 full, probe every tap from the oldest word to past the end.
    for (int k = 1; k <= 14; k++) step(1, 1, 0, 8'(8'h10 + k), 0);
    step(1, 0, 0, 8'h00, 11);
    chk("d12_oldest_q", q1, 8'h13);
    chk("d12_oldest_err", e1, 0);
    for (int a = 12; a <= 15; a++) begin
      step(1, 0, 0, 8'h00, 4'(a));
      chk($sformatf("d12_a%0d_q", a), q1, 0);
      chk($sformatf("d12_a%0d_valid", a), v1, 0);
      chk($sformatf("d12_a%0d_err", a), e1, 1);
      chk($sformatf("d12_a%0d_full", a), f1, 1);
    end

    // Registered tap: moving A without an edge leaves Q alone; one edge later it follows.
    step(1, 0, 0, 8'h00, 0);
    chk("oreg_a0_q", q2, 8'h1E);
    A = 4'd2;
    #2;
    chk("oreg_hold_q", q2, last_exp[7:0]);
    step(1, 0, 0, 8'h00, 2);
    chk("oreg_a2_q", q2, 8'h1C);

    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
